alu_exec_seq: RTL and testbench
===============================

Name: alu_exec_seq

Overview:
- Parametrised successor to the combinational ALU-control decoder.
- Decodes Aluop/funct7/funct3 into the existing 4-bit ALU control code and executes the operation.
- Adds RV32M/RV64M multiply/divide as an iterative multi-cycle engine with a valid/ready handshake, so the EX stage can stall.
- Sits in the EX stage between the ID/EX register and the EX/MEM register.

Parameters:
- XLEN, 32, operand/result width (32 or 64).
- SHAMT_W, $clog2(XLEN), shift-amount width taken from src_b.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- valid_i  in  1  operation presented
- ready_o  out  1  unit can accept an operation this cycle
- flush_i  in  1  abort any in-flight operation (pipeline flush)
- aluop  in  2  00 load/store, 01 branch, 10 R-type, 11 I-type
- funct7  in  7  full funct7 field
- funct3  in  3  funct3 field
- src_a  in  XLEN  operand A (rs1)
- src_b  in  XLEN  operand B (rs2 or immediate)
- control_o  out  4  registered ALU control code of the accepted op
- result_o  out  XLEN  result
- result_valid_o  out  1  one-cycle pulse, result_o valid
- zero_o  out  1  result_o == 0, qualified by result_valid_o
- illegal_o  out  1  one-cycle pulse with result_valid_o for an undecodable op
- busy_o  out  1  multi-cycle op in progress; drives pipeline stall

Behaviour:
- Reset (async, rst_n=0): state IDLE; ready_o=1; result_o=0; control_o=0000; result_valid_o, illegal_o, busy_o=0; iteration counter and internal registers 0.
- Accept: valid_i && ready_o at a rising edge. ready_o=1 only in IDLE.
- Control encoding:
  - add 0010, sub 0110, and 0000, or 0001, sll 0011, slt 0100, sltu 0101, xor 0111, srl 1000, sra 1010.
  - mul/div class 1100; illegal 1111.
- Decode:
  - aluop 00 -> add.
  - aluop 01 -> sub.
  - aluop 10 with funct7=0000000 -> f3 000 add, 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl, 110 or, 111 and.
  - aluop 10 with funct7=0100000 -> f3 000 sub, 101 sra; any other funct3 is illegal.
  - aluop 10 with funct7=0000001 -> M-ext: f3 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
  - aluop 10 with any other funct7 -> illegal.
  - aluop 11 -> funct7 ignored except for f3 001 and f3 101: slli requires funct7[5]=0; srli has funct7[5]=0; srai has funct7[5]=1. Other funct7 bits on shifts are ignored.
- Shifts: amount = src_b[SHAMT_W-1:0].
- slt/sltu: result zero-extended 0 or 1.
- States: IDLE, MUL, DIV, DONE.
  - IDLE + accept, non-M or illegal -> DONE, with the result computed and registered at the accept edge.
  - IDLE + accept, mul class -> MUL.
  - IDLE + accept, div/rem class -> DIV.
  - MUL/DIV: counter counts 0..XLEN-1; at XLEN-1 -> DONE.
  - DONE: result_valid_o=1 for exactly this cycle; next state IDLE.
- Latency, counted from the accept edge:
  - ALU/illegal: result_valid_o in the cycle after accept (1 cycle).
  - M ops: result_valid_o XLEN+1 cycles after accept.
  - Throughput: one ALU op every 2 cycles.
- busy_o=1 in MUL and DIV, else 0.
- Multiply: shift-add on operand magnitudes into a 2*XLEN accumulator.
  - mul returns the low XLEN bits; mulh/mulhsu/mulhu return the high XLEN bits.
  - Sign correction is applied when entering DONE: mulh treats both signed, mulhsu treats A signed and B unsigned, mulhu treats both unsigned.
- Divide: restoring division on magnitudes; quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
- Divide boundaries (handled inside the normal XLEN-cycle timing):
  - Divisor 0: div/divu -> all ones; rem/remu -> src_a.
  - Signed overflow (a = -2^(XLEN-1), b = -1): div -> src_a; rem -> 0.
- Illegal: result_o=0, control_o=1111, illegal_o pulses together with result_valid_o.
- flush_i, highest priority:
  - In MUL/DIV/DONE: next state IDLE; result_valid_o and illegal_o are suppressed in the following cycle.
  - In IDLE: blocks acceptance that cycle.
- A flush that coincides with the DONE cycle does not retract the pulse already shown in that cycle.
- Operands are latched at accept; src_a and src_b changing during MUL/DIV have no effect.
- Reset asserted mid-operation returns the unit to the reset state immediately.

Optional Feature:
- MULDIV_EARLY_OUT_EN defined:
  - MUL with either operand 0 -> DONE directly, result 0, latency 1.
  - DIV/REM with divisor 0 or signed overflow -> DONE directly with the special-case result, latency 1.
- Undefined: every M op takes exactly XLEN+1 cycles regardless of operands.

Test Plan:
- Reset with rst_n=0 mid-DIV -> immediately ready_o=1, result_valid_o=0, busy_o=0, result_o=0.
- aluop=10, funct7=0100000, f3=101, a=0x80000000, b=4 -> result 0xF8000000, control 1010, valid 1 cycle after accept; I-type f3=000 with funct7=0100000 -> addi (control 0010), not sub.
- mulh, a=0xFFFFFFFF (-1), b=0x00000002 -> result 0xFFFFFFFF, result_valid_o 33 cycles after accept, busy_o high for 32 cycles, ready_o low throughout.
- div a=0x80000000, b=0xFFFFFFFF -> 0x80000000; rem for the same operands -> 0; divu a=7, b=0 -> 0xFFFFFFFF; remu a=7, b=0 -> 7; all at 33 cycles without the macro, 1 cycle with it.
- aluop=10, funct7=0000010 -> result 0, control 1111, illegal_o and result_valid_o pulse together, 1 cycle after accept.
- flush_i asserted at iteration 10 of a divu -> no result_valid_o; ready_o=1 the next cycle; a following add 3+4 -> 7 after 1 cycle.

Source files
------------

// File: rtl/alu_exec_seq.sv
// EX-stage ALU with an iterative RV32M/RV64M multiply/divide engine behind a valid/ready handshake.
// Optional: define MULDIV_EARLY_OUT_EN to let trivial M ops (zero operand, div-by-zero, overflow) finish in one cycle.
module alu_exec_seq #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic            flush_i,
  input  logic [1:0]      aluop,
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic [3:0]      control_o,
  output logic [XLEN-1:0] result_o,
  output logic            result_valid_o,
  output logic            zero_o,
  output logic            illegal_o,
  output logic            busy_o
);

  localparam int CW = $clog2(XLEN);

  localparam logic [3:0] C_AND = 4'b0000, C_OR  = 4'b0001, C_ADD = 4'b0010, C_SLL = 4'b0011,
                         C_SLT = 4'b0100, C_SLTU= 4'b0101, C_SUB = 4'b0110, C_XOR = 4'b0111,
                         C_SRL = 4'b1000, C_SRA = 4'b1010, C_MD  = 4'b1100, C_ILL = 4'b1111;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [2*XLEN-1:0]   acc;
  logic [XLEN-1:0]     opnd;
  logic [XLEN-1:0]     op_a;
  logic [2:0]          f3_q;
  logic                res_neg, rem_neg, div0_q, ovf_q, ill_q;

  // ---------------- decode ----------------
  logic [3:0] dec_ctrl;
  logic       dec_m;

  always_comb begin
    dec_ctrl = C_ILL;
    dec_m    = 1'b0;
    case (aluop)
      2'b00: dec_ctrl = C_ADD;
      2'b01: dec_ctrl = C_SUB;
      2'b10: begin
        case (funct7)
          7'b0000000: begin
            case (funct3)
              3'b000: dec_ctrl = C_ADD;
              3'b001: dec_ctrl = C_SLL;
              3'b010: dec_ctrl = C_SLT;
              3'b011: dec_ctrl = C_SLTU;
              3'b100: dec_ctrl = C_XOR;
              3'b101: dec_ctrl = C_SRL;
              3'b110: dec_ctrl = C_OR;
              default: dec_ctrl = C_AND;
            endcase
          end
          7'b0100000: begin
            if (funct3 == 3'b000)      dec_ctrl = C_SUB;
            else if (funct3 == 3'b101) dec_ctrl = C_SRA;
            else                       dec_ctrl = C_ILL;
          end
          7'b0000001: begin
            dec_ctrl = C_MD;
            dec_m    = 1'b1;
          end
          default: dec_ctrl = C_ILL;
        endcase
      end
      default: begin
        // I-type: funct7 only matters for the shift forms
        case (funct3)
          3'b000: dec_ctrl = C_ADD;
          3'b001: dec_ctrl = funct7[5] ? C_ILL : C_SLL;
          3'b010: dec_ctrl = C_SLT;
          3'b011: dec_ctrl = C_SLTU;
          3'b100: dec_ctrl = C_XOR;
          3'b101: dec_ctrl = funct7[5] ? C_SRA : C_SRL;
          3'b110: dec_ctrl = C_OR;
          default: dec_ctrl = C_AND;
        endcase
      end
    endcase
  end

  // ---------------- single-cycle ALU ----------------
  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    alu_res;

  assign shamt = src_b[SHAMT_W-1:0];

  always_comb begin
    alu_res = '0;
    case (dec_ctrl)
      C_ADD:  alu_res = src_a + src_b;
      C_SUB:  alu_res = src_a - src_b;
      C_AND:  alu_res = src_a & src_b;
      C_OR:   alu_res = src_a | src_b;
      C_XOR:  alu_res = src_a ^ src_b;
      C_SLL:  alu_res = src_a << shamt;
      C_SRL:  alu_res = src_a >> shamt;
      C_SRA:  alu_res = $unsigned($signed(src_a) >>> shamt);
      C_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      C_SLTU: alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
      default: alu_res = '0;
    endcase
  end

  // ---------------- M-op setup ----------------
  logic            a_sgn, b_sgn, a_neg, b_neg, in_div0, in_ovf;
  logic [XLEN-1:0] mag_a, mag_b;

  assign a_sgn   = funct3[2] ? ~funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
  assign b_sgn   = funct3[2] ? ~funct3[0] : (funct3[1:0] == 2'b01);
  assign a_neg   = a_sgn & src_a[XLEN-1];
  assign b_neg   = b_sgn & src_b[XLEN-1];
  assign mag_a   = a_neg ? -src_a : src_a;
  assign mag_b   = b_neg ? -src_b : src_b;
  assign in_div0 = (src_b == '0);
  assign in_ovf  = funct3[2] & ~funct3[0] & (src_a == {1'b1, {(XLEN-1){1'b0}}}) & (&src_b);

  // Result of the two division corner cases (div-by-zero, signed overflow)
  function automatic logic [XLEN-1:0] spec_res(input logic is_rem, input logic [XLEN-1:0] a,
                                               input logic dz);
    if (dz) spec_res = is_rem ? a : '1;
    else    spec_res = is_rem ? '0 : a;
  endfunction

`ifdef MULDIV_EARLY_OUT_EN
  logic early_mul, early_div;
  assign early_mul = ~funct3[2] & ((src_a == '0) | (src_b == '0));
  assign early_div =  funct3[2] & (in_div0 | in_ovf);
`endif

  // ---------------- iteration datapath ----------------
  // acc = {hi, lo}: multiply keeps the multiplier in lo and shifts right;
  // divide keeps remainder in hi and dividend/quotient in lo, shifting left.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nxt, div_nxt, prod;
  logic [XLEN:0]     div_rr;
  logic [XLEN-1:0]   div_df, quo, rmd, mul_fin, div_fin;
  logic              div_ge, last;

  assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opnd : {XLEN{1'b0}})};
  assign mul_nxt = {mul_sum, acc[XLEN-1:1]};

  assign div_rr  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign div_ge  = div_rr >= {1'b0, opnd};
  assign div_df  = div_rr[XLEN-1:0] - opnd;
  assign div_nxt = {(div_ge ? div_df : div_rr[XLEN-1:0]), acc[XLEN-2:0], div_ge};

  assign prod    = res_neg ? -mul_nxt : mul_nxt;
  assign mul_fin = (f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  assign quo     = div_nxt[XLEN-1:0];
  assign rmd     = div_nxt[2*XLEN-1:XLEN];
  assign div_fin = (div0_q | ovf_q) ? spec_res(f3_q[1], op_a, div0_q) :
                   f3_q[1]          ? (rem_neg ? -rmd : rmd) :
                                      (res_neg ? -quo : quo);

  assign last    = (cnt == CW'(XLEN-1));

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      result_o  <= '0;
      control_o <= '0;
      ill_q     <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      opnd      <= '0;
      op_a      <= '0;
      f3_q      <= '0;
      res_neg   <= 1'b0;
      rem_neg   <= 1'b0;
      div0_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_i && !flush_i) begin
            control_o <= dec_ctrl;
            ill_q     <= (dec_ctrl == C_ILL);
            cnt       <= '0;
            op_a      <= src_a;
            f3_q      <= funct3;
            res_neg   <= a_neg ^ b_neg;
            rem_neg   <= a_neg;
            div0_q    <= in_div0;
            ovf_q     <= in_ovf;
            if (!dec_m) begin
              result_o <= alu_res;
              state    <= DONE;
            end
`ifdef MULDIV_EARLY_OUT_EN
            else if (early_mul) begin
              result_o <= '0;
              state    <= DONE;
            end else if (early_div) begin
              result_o <= spec_res(funct3[1], src_a, in_div0);
              state    <= DONE;
            end
`endif
            else if (!funct3[2]) begin
              acc   <= {{XLEN{1'b0}}, mag_b};
              opnd  <= mag_a;
              state <= MUL;
            end else begin
              acc   <= {{XLEN{1'b0}}, mag_a};
              opnd  <= mag_b;
              state <= DIV;
            end
          end
        end
        MUL: begin
          if (flush_i) state <= IDLE;
          else begin
            acc <= mul_nxt;
            cnt <= cnt + 1'b1;
            if (last) begin
              result_o <= mul_fin;
              state    <= DONE;
            end
          end
        end
        DIV: begin
          if (flush_i) state <= IDLE;
          else begin
            acc <= div_nxt;
            cnt <= cnt + 1'b1;
            if (last) begin
              result_o <= div_fin;
              state    <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ready_o        = (state == IDLE);
  assign busy_o         = (state == MUL) || (state == DIV);
  assign result_valid_o = (state == DONE);
  assign illegal_o      = (state == DONE) && ill_q;
  assign zero_o         = result_valid_o && (result_o == '0);

endmodule

// File: tb/tb_alu_exec_seq.sv
// Table-driven bench for alu_exec_seq with a scoreboard queue checked at result_valid_o.
module tb_alu_exec_seq;
  localparam int XLEN = 32;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int SPL = 1;
`else
  localparam int SPL = 33;
`endif
  localparam int ML = 33;
  localparam logic [6:0] F0 = 7'b0000000, FA = 7'b0100000, FM = 7'b0000001, FX = 7'b0000010;

  logic            clk = 1'b0, rst_n = 1'b0, valid_i = 1'b0, flush_i = 1'b0;
  logic [1:0]      aluop = '0;
  logic [6:0]      funct7 = '0;
  logic [2:0]      funct3 = '0;
  logic [XLEN-1:0] src_a = '0, src_b = '0;
  logic            ready_o, result_valid_o, zero_o, illegal_o, busy_o;
  logic [3:0]      control_o;
  logic [XLEN-1:0] result_o;

  alu_exec_seq #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o), .flush_i(flush_i),
    .aluop(aluop), .funct7(funct7), .funct3(funct3), .src_a(src_a), .src_b(src_b),
    .control_o(control_o), .result_o(result_o), .result_valid_o(result_valid_o),
    .zero_o(zero_o), .illegal_o(illegal_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] aluop; logic [6:0] f7; logic [2:0] f3;
    logic [31:0] a, b, res; logic [3:0] ctrl; logic ill; int lat;
  } vec_t;
  typedef struct { logic [31:0] res; logic [3:0] ctrl; logic ill; int lat; int cyc0; } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int checks = 0, errors = 0, cyc = 0, busy_cnt = 0, ready_cnt = 0;

  function automatic vec_t mk(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] b, input logic [31:0] res,
                              input logic [3:0] ctrl, input logic ill, input int lat);
    vec_t v;
    v.aluop = op; v.f7 = f7; v.f3 = f3; v.a = a; v.b = b;
    v.res = res; v.ctrl = ctrl; v.ill = ill; v.lat = lat;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pop the scoreboard on every result pulse
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (busy_o)  busy_cnt++;
    if (ready_o) ready_cnt++;
    if (rst_n && result_valid_o) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid actual=%0h required=none", result_o);
      end else begin
        e = sb.pop_front();
        chk("result",  result_o,  e.res);
        chk("control", control_o, e.ctrl);
        chk("illegal", illegal_o, e.ill);
        chk("zero",    zero_o,    e.res == 0);
        chk("latency", cyc - e.cyc0 + 1, e.lat);
      end
    end
  end

  task automatic issue(input vec_t v, input bit push);
    exp_t e;
    int n = 0;
    while (!ready_o && n < 200) begin @(negedge clk); n++; end
    if (!ready_o) chk("ready_timeout", 0, 1);
    @(negedge clk);
    aluop = v.aluop; funct7 = v.f7; funct3 = v.f3; src_a = v.a; src_b = v.b;
    valid_i = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    src_a = $urandom; src_b = $urandom;
    busy_cnt = 0; ready_cnt = 0;
    if (push) begin
      e.res = v.res; e.ctrl = v.ctrl; e.ill = v.ill; e.lat = v.lat; e.cyc0 = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin @(negedge clk); #1; n++; end
    if (sb.size() != 0) begin
      chk("result_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic run(input vec_t v);
    issue(v, 1'b1);
    wait_done();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    tbl.push_back(mk(2'b00, F0, 3'b000, 32'd5, 32'd7, 32'd12, 4'b0010, 0, 1));
    tbl.push_back(mk(2'b01, F0, 3'b000, 32'd9, 32'd9, 32'd0, 4'b0110, 0, 1));
    tbl.push_back(mk(2'b10, FA, 3'b101, 32'h80000000, 32'd4, 32'hF8000000, 4'b1010, 0, 1));
    tbl.push_back(mk(2'b11, FA, 3'b000, 32'd10, 32'd3, 32'd13, 4'b0010, 0, 1));
    tbl.push_back(mk(2'b10, F0, 3'b010, 32'hFFFFFFFF, 32'd1, 32'd1, 4'b0100, 0, 1));
    tbl.push_back(mk(2'b10, F0, 3'b011, 32'hFFFFFFFF, 32'd1, 32'd0, 4'b0101, 0, 1));
    tbl.push_back(mk(2'b10, F0, 3'b100, 32'hF0F0, 32'hFF00, 32'h0FF0, 4'b0111, 0, 1));
    tbl.push_back(mk(2'b10, F0, 3'b001, 32'd1, 32'd35, 32'd8, 4'b0011, 0, 1));
    tbl.push_back(mk(2'b10, F0, 3'b101, 32'h80000000, 32'd4, 32'h08000000, 4'b1000, 0, 1));
    tbl.push_back(mk(2'b10, F0, 3'b110, 32'hA, 32'h5, 32'hF, 4'b0001, 0, 1));
    tbl.push_back(mk(2'b10, F0, 3'b111, 32'hC, 32'hA, 32'h8, 4'b0000, 0, 1));
    tbl.push_back(mk(2'b10, FA, 3'b000, 32'd3, 32'd5, 32'hFFFFFFFE, 4'b0110, 0, 1));
    tbl.push_back(mk(2'b10, FX, 3'b000, 32'd3, 32'd5, 32'd0, 4'b1111, 1, 1));
    tbl.push_back(mk(2'b10, FA, 3'b001, 32'd3, 32'd5, 32'd0, 4'b1111, 1, 1));
    tbl.push_back(mk(2'b11, FA, 3'b001, 32'd3, 32'd1, 32'd0, 4'b1111, 1, 1));
    tbl.push_back(mk(2'b11, FA, 3'b101, 32'h80000000, 32'd4, 32'hF8000000, 4'b1010, 0, 1));
    tbl.push_back(mk(2'b11, F0, 3'b101, 32'h80000000, 32'd4, 32'h08000000, 4'b1000, 0, 1));
    tbl.push_back(mk(2'b10, FM, 3'b000, 32'd3, 32'hFFFFFFFE, 32'hFFFFFFFA, 4'b1100, 0, ML));
    tbl.push_back(mk(2'b10, FM, 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 4'b1100, 0, ML));
    tbl.push_back(mk(2'b10, FM, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1100, 0, ML));
    tbl.push_back(mk(2'b10, FM, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'b1100, 0, ML));
    tbl.push_back(mk(2'b10, FM, 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 4'b1100, 0, ML));
    tbl.push_back(mk(2'b10, FM, 3'b000, 32'd0, 32'd5, 32'd0, 4'b1100, 0, SPL));
    tbl.push_back(mk(2'b10, FM, 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 4'b1100, 0, ML));
    tbl.push_back(mk(2'b10, FM, 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 4'b1100, 0, ML));
    tbl.push_back(mk(2'b10, FM, 3'b100, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 4'b1100, 0, ML));
    tbl.push_back(mk(2'b10, FM, 3'b110, 32'd7, 32'hFFFFFFFE, 32'd1, 4'b1100, 0, ML));
    tbl.push_back(mk(2'b10, FM, 3'b101, 32'd100, 32'd7, 32'd14, 4'b1100, 0, ML));
    tbl.push_back(mk(2'b10, FM, 3'b111, 32'd100, 32'd7, 32'd2, 4'b1100, 0, ML));
    tbl.push_back(mk(2'b10, FM, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 4'b1100, 0, SPL));
    tbl.push_back(mk(2'b10, FM, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 4'b1100, 0, SPL));
    tbl.push_back(mk(2'b10, FM, 3'b101, 32'd7, 32'd0, 32'hFFFFFFFF, 4'b1100, 0, SPL));
    tbl.push_back(mk(2'b10, FM, 3'b111, 32'd7, 32'd0, 32'd7, 4'b1100, 0, SPL));
    tbl.push_back(mk(2'b10, FM, 3'b100, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 4'b1100, 0, SPL));
    tbl.push_back(mk(2'b10, FM, 3'b110, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 4'b1100, 0, SPL));

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", ready_o, 1);
    chk("rst_valid", result_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_result", result_o, 0);
    chk("rst_control", control_o, 0);
    chk("rst_illegal", illegal_o, 0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) run(tbl[i]);

    // mulh -1 * 2: busy for XLEN cycles, ready low throughout
    run(mk(2'b10, FM, 3'b001, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 4'b1100, 0, ML));
    chk("mulh_busy_cycles", busy_cnt, 32);
    chk("mulh_ready_cycles", ready_cnt, 0);

    // Flush in IDLE blocks acceptance
    @(negedge clk);
    aluop = 2'b00; src_a = 32'd1; src_b = 32'd1; valid_i = 1'b1; flush_i = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b0; flush_i = 1'b0;
    chk("flush_idle_ready", ready_o, 1);
    repeat (3) @(negedge clk);

    // Flush a divu at iteration 10
    issue(mk(2'b10, FM, 3'b101, 32'd100, 32'd7, 32'd14, 4'b1100, 0, ML), 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    @(negedge clk);
    #1;
    chk("flush_ready", ready_o, 1);
    chk("flush_busy", busy_o, 0);
    chk("flush_valid", result_valid_o, 0);
    repeat (40) @(negedge clk);
    run(mk(2'b10, F0, 3'b000, 32'd3, 32'd4, 32'd7, 4'b0010, 0, 1));

    // Reset mid-DIV
    issue(mk(2'b10, FM, 3'b100, 32'd100, 32'd3, 32'd33, 4'b1100, 0, ML), 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("middiv_rst_ready", ready_o, 1);
    chk("middiv_rst_valid", result_valid_o, 0);
    chk("middiv_rst_busy", busy_o, 0);
    chk("middiv_rst_result", result_o, 0);
    chk("middiv_rst_control", control_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
